// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/decode/execute sequencer and its datapath.
package cpu_pkg;

  localparam int CPU_PC_W   = 8;
  localparam int CPU_DATA_W = 8;

  typedef enum logic [2:0] {
    S_F1   = 3'd0,
    S_F2   = 3'd1,
    S_F3   = 3'd2,
    S_EX   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // Instruction class lives in opcode[7:6]
  localparam logic [1:0] CL_ALU  = 2'b00;
  localparam logic [1:0] CL_JMP  = 2'b01;
  localparam logic [1:0] CL_MISC = 2'b10;
  localparam logic [1:0] CL_HALT = 2'b11;

  typedef enum logic [2:0] {
    C_ALWAYS = 3'd0,
    C_Z      = 3'd1,
    C_NZ     = 3'd2,
    C_C      = 3'd3,
    C_NC     = 3'd4,
    C_S      = 3'd5,
    C_OV     = 3'd6,
    C_P      = 3'd7
  } cond_t;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  // EX-cycle strobe pattern {A_ce, C_OV_en, C_OV_kasowanie} for a decoded class.
  // A_ce and the C/OV clear come from disjoint classes, so they never overlap.
  function automatic logic [2:0] ex_strobes(input logic [1:0] cls, input logic func0);
    logic [2:0] s;
    s = 3'b000;
    case (cls)
      CL_ALU:  s = 3'b110;
      CL_MISC: s = func0 ? 3'b001 : 3'b000;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/warunek_skoku.sv
// Jump condition evaluator: selects the flag test named by the condition code.
module warunek_skoku
  import cpu_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_c,
  input  logic       i_ov,
  input  logic       i_p,
  input  logic       i_z,
  input  logic       i_s,
  output logic       o_take
);

  // Map condition code onto the registered flags
  always_comb begin
    o_take = 1'b0;
    case (cond_t'(i_cond))
      C_ALWAYS: o_take = 1'b1;
      C_Z:      o_take = i_z;
      C_NZ:     o_take = ~i_z;
      C_C:      o_take = i_c;
      C_NC:     o_take = ~i_c;
      C_S:      o_take = i_s;
      C_OV:     o_take = i_ov;
      C_P:      o_take = i_p;
      default:  o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/jednostka_sterujaca.sv
// Fetch/decode/execute sequencer: 4-cycle instruction loop (F1,F2,F3,EX) over a
// registered program ROM, driving the ALU/accumulator/flag strobes.
module jednostka_sterujaca
  import cpu_pkg::*;
#(
  parameter int PC_W   = CPU_PC_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              C_out,
  input  logic              OV_out,
  input  logic              P_out,
  input  logic              Z_out,
  input  logic              S_out,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] b,
  output logic              A_ce,
  output logic              C_OV_en,
  output logic              C_OV_kasowanie,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [PC_W-1:0]   r_prog_addr, w_prog_addr_nxt;
  logic [4:0]        r_opcode, w_opcode_nxt;     // {class, opcode[2:0]}
  logic [DATA_W-1:0] r_imm, w_imm_nxt;
  logic [2:0]        r_alu_op, w_alu_op_nxt;
  logic [2:0]        r_strobes, w_strobes_nxt;   // {A_ce, C_OV_en, C_OV_kasowanie}
  logic              r_halted, w_halted_nxt;

  logic [1:0]        w_cls_in;
  logic [2:0]        w_func_in;
  logic [PC_W-1:0]   w_pc_inc1;
  logic [PC_W-1:0]   w_pc_seq;
  logic [PC_W-1:0]   w_pc_tgt;
  logic              w_cond_true;
  logic              w_take;

  assign w_cls_in  = prog_data[DATA_W-1 -: 2];
  assign w_func_in = prog_data[2:0];
  assign w_pc_inc1 = r_pc + PC_W'(1'b1);
  assign w_pc_seq  = r_pc + PC_W'(2'd2);
  assign w_pc_tgt  = PC_W'(r_imm);
  assign w_take    = (r_opcode[4:3] == CL_JMP) && w_cond_true;

  warunek_skoku u_warunek_skoku (
    .i_cond (r_opcode[2:0]),
    .i_c    (C_out),
    .i_ov   (OV_out),
    .i_p    (P_out),
    .i_z    (Z_out),
    .i_s    (S_out),
    .o_take (w_cond_true)
  );

  // Next-state and next-register decode for the instruction sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_prog_addr_nxt = r_prog_addr;
    w_opcode_nxt    = r_opcode;
    w_imm_nxt       = r_imm;
    w_alu_op_nxt    = r_alu_op;
    w_strobes_nxt   = 3'b000;
    w_halted_nxt    = r_halted;
    case (r_state)
      S_F1: begin
        if (run) begin
          w_state_nxt     = S_F2;
          w_prog_addr_nxt = w_pc_inc1;
        end else begin
          w_state_nxt     = S_F1;
        end
      end
      S_F2: begin
        w_opcode_nxt = {w_cls_in, w_func_in};
        w_alu_op_nxt = (w_cls_in == CL_ALU) ? w_func_in : OP_LOAD;
        w_state_nxt  = S_F3;
      end
      S_F3: begin
        w_imm_nxt     = prog_data;
        w_strobes_nxt = ex_strobes(r_opcode[4:3], r_opcode[0]);
        w_state_nxt   = S_EX;
      end
      S_EX: begin
        if (w_take) begin
          w_pc_nxt = w_pc_tgt;
        end else begin
          w_pc_nxt = w_pc_seq;
        end
        w_prog_addr_nxt = w_pc_nxt;
        if (r_opcode[4:3] == CL_HALT) begin
          w_state_nxt  = S_HALT;
          w_halted_nxt = 1'b1;
        end else begin
          w_state_nxt  = S_F1;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_F1;
      end
    endcase
  end

  // State and datapath-control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_F1;
      r_pc        <= '0;
      r_prog_addr <= '0;
      r_opcode    <= 5'd0;
      r_imm       <= '0;
      r_alu_op    <= 3'd0;
      r_strobes   <= 3'b000;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_prog_addr <= w_prog_addr_nxt;
      r_opcode    <= w_opcode_nxt;
      r_imm       <= w_imm_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_strobes   <= w_strobes_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  assign prog_addr      = r_prog_addr;
  assign pc             = r_pc;
  assign alu_op         = r_alu_op;
  assign b              = r_imm;
  assign halted         = r_halted;
  // Reset asserted during EX must suppress the strobe already in flight
  assign A_ce           = r_strobes[2] & rst;
  assign C_OV_en        = r_strobes[1] & rst;
  assign C_OV_kasowanie = r_strobes[0] & rst;

endmodule

// File: tb/tb_jednostka_sterujaca.sv
// Bench for jednostka_sterujaca: registered ROM, behavioural ALU/accumulator/flags,
// and an instruction-level reference interpreter.
module tb_jednostka_sterujaca;

  logic       clk, rst, run;
  logic [7:0] prog_addr, prog_data, b, pc;
  logic       C_out, OV_out, P_out, Z_out, S_out;
  logic [2:0] alu_op;
  logic       A_ce, C_OV_en, C_OV_kasowanie, halted;

  logic [7:0] rom [256];
  logic [7:0] acc;
  logic       fc, fov, fp, fz, fs, env_clr;
  logic [9:0] alu_res;

  // reference interpreter state
  logic [7:0] m_pc, m_acc;
  logic       m_c, m_ov, m_z, m_s, m_p, m_halt;

  int checks = 0;
  int errors = 0;

  jednostka_sterujaca dut (
    .clk(clk), .rst(rst), .run(run), .prog_addr(prog_addr), .prog_data(prog_data),
    .C_out(C_out), .OV_out(OV_out), .P_out(P_out), .Z_out(Z_out), .S_out(S_out),
    .alu_op(alu_op), .b(b), .A_ce(A_ce), .C_OV_en(C_OV_en),
    .C_OV_kasowanie(C_OV_kasowanie), .pc(pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {carry, overflow, result}
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] bv);
    logic [8:0] s; logic [7:0] r; logic c, ov;
    s = 9'd0; r = 8'd0; c = 1'b0; ov = 1'b0;
    case (op)
      3'd0: r = bv;
      3'd1: r = a & bv;
      3'd2: r = a | bv;
      3'd3: r = a ^ bv;
      3'd4: begin s = {1'b0, a} + {1'b0, bv}; r = s[7:0]; c = s[8]; ov = (a[7] == bv[7]) && (r[7] != a[7]); end
      3'd5: begin s = {1'b0, a} - {1'b0, bv}; r = s[7:0]; c = s[8]; ov = (a[7] != bv[7]) && (r[7] != a[7]); end
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {c, ov, r};
  endfunction

  assign alu_res = alu_f(alu_op, acc, b);
  assign C_out = fc;  assign OV_out = fov;  assign P_out = fp;
  assign Z_out = fz;  assign S_out = fs;

  // Program ROM: data valid one cycle after the address
  always_ff @(posedge clk) prog_data <= rom[prog_addr];

  // Accumulator and flag registers driven by the sequencer strobes
  always_ff @(posedge clk) begin
    if (env_clr) begin
      acc <= 8'h00; fc <= 1'b0; fov <= 1'b0; fp <= 1'b0; fz <= 1'b0; fs <= 1'b0;
    end else begin
      if (A_ce) begin
        acc <= alu_res[7:0]; fz <= (alu_res[7:0] == 8'h00); fs <= alu_res[7]; fp <= ^alu_res[7:0];
      end
      if (A_ce && C_OV_en) begin fc <= alu_res[9]; fov <= alu_res[8]; end
      if (C_OV_kasowanie) begin fc <= 1'b0; fov <= 1'b0; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
  endtask

  task automatic do_reset(input bit clr_env);
    rst = 1'b0; run = 1'b0; env_clr = clr_env;
    step(); step();
    env_clr = 1'b0;
    m_pc = 8'h00; m_halt = 1'b0;
    if (clr_env) begin
      m_acc = 8'h00; m_c = 1'b0; m_ov = 1'b0; m_z = 1'b0; m_s = 1'b0; m_p = 1'b0;
    end
  endtask

  // Execute one instruction from S_F1 (run already 1) and check every stage against the interpreter
  task automatic run_instr(input string tag);
    logic [7:0] pc0, pc1, opc, imm, nxt;
    logic [2:0] exp_op, exp_stb;
    logic [9:0] r;
    logic       take;
    pc0 = m_pc; pc1 = pc0 + 8'd1; nxt = pc0 + 8'd2;
    opc = rom[pc0]; imm = rom[pc1];
    exp_op = (opc[7:6] == 2'b00) ? opc[2:0] : 3'd0;
    exp_stb = 3'b000; take = 1'b0;
    case (opc[7:6])
      2'b00: begin
        r = alu_f(opc[2:0], m_acc, imm);
        m_acc = r[7:0]; m_c = r[9]; m_ov = r[8];
        m_z = (r[7:0] == 8'h00); m_s = r[7]; m_p = ^r[7:0];
        exp_stb = 3'b110;
      end
      2'b01: begin
        case (opc[2:0])
          3'd0: take = 1'b1;   3'd1: take = m_z;    3'd2: take = !m_z;
          3'd3: take = m_c;    3'd4: take = !m_c;   3'd5: take = m_s;
          3'd6: take = m_ov;   default: take = m_p;
        endcase
        if (take) nxt = imm;
      end
      2'b10: if (opc[0]) begin m_c = 1'b0; m_ov = 1'b0; exp_stb = 3'b001; end
      default: m_halt = 1'b1;
    endcase
    m_pc = nxt;

    step(); // S_F2
    checks++;
    if ({A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000 || prog_addr !== pc1 || pc !== pc0)
      begin errors++; $display("FAIL %s.f2 stb=%b addr=%h pc=%h exp stb=000 addr=%h pc=%h", tag, {A_ce, C_OV_en, C_OV_kasowanie}, prog_addr, pc, pc1, pc0); end
    step(); // S_F3
    checks++;
    if (alu_op !== exp_op || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
      begin errors++; $display("FAIL %s.f3 alu_op=%0d stb=%b exp alu_op=%0d stb=000", tag, alu_op, {A_ce, C_OV_en, C_OV_kasowanie}, exp_op); end
    step(); // S_EX
    checks++;
    if ({A_ce, C_OV_en, C_OV_kasowanie} !== exp_stb || b !== imm || alu_op !== exp_op || pc !== pc0)
      begin errors++; $display("FAIL %s.ex stb=%b b=%h op=%0d pc=%h exp stb=%b b=%h op=%0d pc=%h", tag, {A_ce, C_OV_en, C_OV_kasowanie}, b, alu_op, pc, exp_stb, imm, exp_op, pc0); end
    step(); // back in S_F1 (or S_HALT)
    checks++;
    if (pc !== nxt || prog_addr !== nxt || halted !== m_halt || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
      begin errors++; $display("FAIL %s.next pc=%h addr=%h halted=%b exp pc=%h addr=%h halted=%b", tag, pc, prog_addr, halted, nxt, nxt, m_halt); end
    checks++;
    if (acc !== m_acc || fc !== m_c || fov !== m_ov || fz !== m_z || fs !== m_s || fp !== m_p)
      begin errors++; $display("FAIL %s.data acc=%h czso p=%b%b%b%b%b exp acc=%h %b%b%b%b%b", tag, acc, fc, fz, fs, fov, fp, m_acc, m_c, m_z, m_s, m_ov, m_p); end
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset(1'b1);
    checks++;
    if ({prog_addr, alu_op, b, A_ce, C_OV_en, C_OV_kasowanie, pc, halted} !== 31'd0)
      begin errors++; $display("FAIL reset.outputs got addr=%h op=%0d b=%h stb=%b pc=%h halted=%b exp all 0", prog_addr, alu_op, b, {A_ce, C_OV_en, C_OV_kasowanie}, pc, halted); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (prog_addr !== 8'h00 || pc !== 8'h00 || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000 || halted !== 1'b0)
        begin errors++; $display("FAIL reset.idle cycle %0d addr=%h pc=%h stb=%b exp 0", i, prog_addr, pc, {A_ce, C_OV_en, C_OV_kasowanie}); end
    end
    run = 1'b1;
    run_instr("reset_first");
  endtask

  task automatic test_alu_seq();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h04; rom[3] = 8'h04;
    do_reset(1'b1); rst = 1'b1; run = 1'b1;
    run_instr("alu_load");
    checks++;
    if (acc !== 8'h05) begin errors++; $display("FAIL alu.load acc=%h exp 05", acc); end
    run_instr("alu_add");
    checks++;
    if (acc !== 8'h09) begin errors++; $display("FAIL alu.add acc=%h exp 09", acc); end
  endtask

  task automatic test_jumps();
    clear_rom();
    rom[8'h00] = 8'h00; rom[8'h01] = 8'h00;
    rom[8'h02] = 8'h41; rom[8'h03] = 8'h10;
    rom[8'h10] = 8'h00; rom[8'h11] = 8'h01;
    rom[8'h12] = 8'h41; rom[8'h13] = 8'h30;
    rom[8'h14] = 8'h00; rom[8'h15] = 8'hFF;
    rom[8'h16] = 8'h04; rom[8'h17] = 8'h01;
    rom[8'h18] = 8'h43; rom[8'h19] = 8'h40;
    rom[8'h40] = 8'h80; rom[8'h41] = 8'h00;
    do_reset(1'b1); rst = 1'b1; run = 1'b1;
    run_instr("jz_load0"); run_instr("jz_taken");
    checks++;
    if (pc !== 8'h10) begin errors++; $display("FAIL jmp.z_taken pc=%h exp 10", pc); end
    run_instr("jz_load1"); run_instr("jz_not");
    checks++;
    if (pc !== 8'h14) begin errors++; $display("FAIL jmp.z_not pc=%h exp 14", pc); end
    run_instr("jc_load"); run_instr("jc_add"); run_instr("jc_taken");
    checks++;
    if (pc !== 8'h40) begin errors++; $display("FAIL jmp.c_taken pc=%h exp 40", pc); end
    run_instr("jmp_nop");
  endtask

  task automatic test_clc_halt();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'hFF; rom[2] = 8'h04; rom[3] = 8'h01;
    rom[4] = 8'h81; rom[5] = 8'h00; rom[6] = 8'hC0; rom[7] = 8'h00;
    do_reset(1'b1); rst = 1'b1; run = 1'b1;
    run_instr("clc_load"); run_instr("clc_add");
    checks++;
    if (fc !== 1'b1) begin errors++; $display("FAIL clc.carry_set C=%b exp 1", fc); end
    run_instr("clc");
    checks++;
    if (fc !== 1'b0) begin errors++; $display("FAIL clc.cleared C=%b exp 0", fc); end
    run_instr("halt");
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (halted !== 1'b1 || prog_addr !== 8'h08 || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
        begin errors++; $display("FAIL halt.hold cycle %0d halted=%b addr=%h stb=%b exp 1 08 000", i, halted, prog_addr, {A_ce, C_OV_en, C_OV_kasowanie}); end
    end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h04; rom[3] = 8'h03;
    do_reset(1'b1); rst = 1'b1; run = 1'b1;
    run_instr("mid_load");
    step(); step(); step(); // into S_EX of the ADD
    checks++;
    if (A_ce !== 1'b1) begin errors++; $display("FAIL mid.ex_before A_ce=%b exp 1", A_ce); end
    rst = 1'b0; #1;
    checks++;
    if ({A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
      begin errors++; $display("FAIL mid.strobe_gated stb=%b exp 000", {A_ce, C_OV_en, C_OV_kasowanie}); end
    step();
    checks++;
    if (acc !== 8'h05 || pc !== 8'h00 || prog_addr !== 8'h00 || halted !== 1'b0)
      begin errors++; $display("FAIL mid.after acc=%h pc=%h addr=%h exp 05 00 00", acc, pc, prog_addr); end
    rst = 1'b1; run = 1'b1; m_pc = 8'h00; m_halt = 1'b0;
    run_instr("mid_restart_load"); run_instr("mid_restart_add");
    checks++;
    if (acc !== 8'h08) begin errors++; $display("FAIL mid.final acc=%h exp 08", acc); end
  endtask

  task automatic test_wrap_run();
    clear_rom();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h00;
    do_reset(1'b1); rst = 1'b1; run = 1'b1;
    run_instr("wrap_jmp"); run_instr("wrap_nop");
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap.pc pc=%h exp 00", pc); end
    step(); step(); run = 1'b0; step(); step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pc !== 8'hFE || prog_addr !== 8'hFE || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
        begin errors++; $display("FAIL run.hold cycle %0d pc=%h addr=%h stb=%b exp FE FE 000", i, pc, prog_addr, {A_ce, C_OV_en, C_OV_kasowanie}); end
      step();
    end
    m_pc = 8'hFE; run = 1'b1;
    run_instr("run_resume");
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < 256; a++) begin
        v = 8'($urandom);
        if (v[7:6] == 2'b11 && $urandom_range(0, 15) != 0) v[7:6] = 2'b00;
        rom[a] = v;
      end
      do_reset(1'b1); rst = 1'b1; run = 1'b1;
      for (int n = 0; n < 40 && !m_halt; n++) run_instr("rand");
      if (m_halt) begin
        for (int i = 0; i < 3; i++) begin
          step();
          checks++;
          if (halted !== 1'b1 || {A_ce, C_OV_en, C_OV_kasowanie} !== 3'b000)
            begin errors++; $display("FAIL rand.halt halted=%b stb=%b exp 1 000", halted, {A_ce, C_OV_en, C_OV_kasowanie}); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; env_clr = 1'b1;
    test_reset();
    test_alu_seq();
    test_jumps();
    test_clc_halt();
    test_reset_mid();
    test_wrap_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
